// File: rtl/lock_key_pkg.sv
// Shared constants for the c432 unlock-key loader: key bit positions and FSM state codes.
package lock_key_pkg;

  localparam int unsigned KEY_W_DEF = 5;

  localparam int unsigned KEY_P1 = 0;
  localparam int unsigned KEY_P2 = 1;
  localparam int unsigned KEY_P3 = 2;
  localparam int unsigned KEY_P4 = 3;
  localparam int unsigned KEY_X1 = 4;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_SHIFT   = 3'd1;
  localparam logic [ST_W-1:0] ST_CHECK   = 3'd2;
  localparam logic [ST_W-1:0] ST_ARMED   = 3'd3;
  localparam logic [ST_W-1:0] ST_LOCKOUT = 3'd4;

endpackage

// File: rtl/key_shift_par.sv
// Serial key deserializer: KEY_W data bits LSB first, then one even-parity bit.
module key_shift_par #(
  parameter int unsigned KEY_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             din,
  output logic [KEY_W-1:0] data,
  output logic             done,
  output logic             parity_ok
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  logic [CNT_W-1:0] count;

  // done means all data bits are in; the next load is the parity bit.
  // parity_ok tracks even parity over every loaded bit, data and parity alike.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data      <= '0;
      count     <= '0;
      done      <= 1'b0;
      parity_ok <= 1'b1;
    end else if (load) begin
      parity_ok <= parity_ok ^ din;
      if (!done) begin
        for (int i = 0; i < KEY_W; i++) begin
          if (count == CNT_W'(i)) data[i] <= din;
        end
        count <= count + CNT_W'(1);
        done  <= (count == CNT_W'(KEY_W - 1));
      end
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// Unlock-key loader for the locked c432 core: receives a parity-checked serial
// key frame, drives it onto the core key inputs, and latches lockout after repeated failures.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            key_start,
  input  logic                            key_bit,
  input  logic                            key_valid,
  output logic                            key_ready,
  output logic [KEY_W-1:0]                key_out,
  output logic                            key_applied,
  output logic                            key_err,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic                            lockout
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  logic [ST_W-1:0]   state, state_nxt;
  logic              sh_clear, sh_load;
  logic [KEY_W-1:0]  sh_data;
  logic              sh_done, sh_parity_ok;
  logic              arm_pend, arm_pend_nxt;
  logic [KEY_W-1:0]  key_out_nxt;
  logic              applied_nxt, err_nxt;
  logic [FAIL_W-1:0] fail_nxt;

  key_shift_par #(.KEY_W(KEY_W)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear     (sh_clear),
    .load      (sh_load),
    .din       (key_bit),
    .data      (sh_data),
    .done      (sh_done),
    .parity_ok (sh_parity_ok)
  );

  // Next-state and next-output logic; key_ready is high exactly in SHIFT.
  always_comb begin
    state_nxt    = state;
    sh_clear     = 1'b0;
    sh_load      = 1'b0;
    arm_pend_nxt = 1'b0;
    key_out_nxt  = key_out;
    applied_nxt  = key_applied;
    err_nxt      = 1'b0;
    fail_nxt     = fail_cnt;
    case (state)
      ST_IDLE: begin
        if (key_start) begin
          sh_clear  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (key_start) begin
          sh_clear = 1'b1;
        end else if (key_valid && key_ready) begin
          sh_load = 1'b1;
          if (sh_done) state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sh_parity_ok) begin
          arm_pend_nxt = 1'b1;
          state_nxt    = ST_ARMED;
        end else begin
          err_nxt = 1'b1;
          if (fail_cnt < FAIL_W'(MAX_FAIL)) fail_nxt = fail_cnt + FAIL_W'(1);
          state_nxt = (fail_nxt == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
        end
      end
      ST_ARMED: begin
        // A re-key takes priority over a pending load so no stale key is ever applied.
        if (key_start) begin
          sh_clear    = 1'b1;
          key_out_nxt = '0;
          applied_nxt = 1'b0;
          state_nxt   = ST_SHIFT;
        end else if (arm_pend) begin
          key_out_nxt = sh_data;
          applied_nxt = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        key_out_nxt = '0;
        applied_nxt = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      arm_pend    <= 1'b0;
      key_ready   <= 1'b0;
      key_out     <= '0;
      key_applied <= 1'b0;
      key_err     <= 1'b0;
      fail_cnt    <= '0;
      lockout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      arm_pend    <= arm_pend_nxt;
      key_ready   <= (state_nxt == ST_SHIFT);
      key_out     <= key_out_nxt;
      key_applied <= applied_nxt;
      key_err     <= err_nxt;
      fail_cnt    <= fail_nxt;
      lockout     <= (state_nxt == ST_LOCKOUT);
    end
  end

endmodule
